// File: rtl/arb_client_pkg.sv
// Shared types and constants for the arbiter requester-side client.
package arb_client_pkg;

    localparam int unsigned PEND_CNT_W = 4;

    typedef logic [PEND_CNT_W-1:0] pend_cnt_t;
    typedef logic [7:0]            wait_cnt_t;

    localparam wait_cnt_t WAIT_MAX = 8'hFF;

endpackage

// File: rtl/arb_client_port.sv
// One requester port: pending-transaction count, starvation timer and
// registered done/drop pulses.
module arb_client_port
    import arb_client_pkg::*;
#(
    parameter int unsigned CNT_W        = 4,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic gnt,
    output logic req,
    output logic full,
    output logic done,
    output logic drop,
    output logic starve
);

    logic [CNT_W-1:0] cnt;
    wait_cnt_t        wait_cnt;
    logic             acc;

    // Request, full and starvation flags are pure functions of registered state.
    always_comb begin
        req    = (cnt != '0);
        full   = (cnt == '1);
        acc    = req & gnt;
        starve = (wait_cnt >= wait_cnt_t'(STARVE_LIMIT));
    end

    // Counter, starvation timer and completion/drop pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            wait_cnt <= '0;
            done     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            done <= acc;
            drop <= push & ~acc & full;

            if (push && !acc && !full) begin
                cnt <= cnt + 1'b1;
            end else if (!push && acc) begin
                cnt <= cnt - 1'b1;
            end

            if (acc || (cnt == '0)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_req_client.sv
// Requester-side agent for a fixed-priority arbiter: NUM_PORTS independent
// port trackers plus a sticky checker for arbiter protocol violations.
module arb_req_client
    import arb_client_pkg::*;
#(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned CNT_W        = PEND_CNT_W,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] push_i,
    input  logic [NUM_PORTS-1:0] gnt_i,
    output logic [NUM_PORTS-1:0] req_o,
    output logic [NUM_PORTS-1:0] full_o,
    output logic [NUM_PORTS-1:0] done_o,
    output logic [NUM_PORTS-1:0] drop_o,
    output logic [NUM_PORTS-1:0] starve_o,
    output logic                 grant_err_o
);

    logic proto_err;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        arb_client_port #(
            .CNT_W        (CNT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_port (
            .clk    (clk),
            .reset  (reset),
            .push   (push_i[p]),
            .gnt    (gnt_i[p]),
            .req    (req_o[p]),
            .full   (full_o[p]),
            .done   (done_o[p]),
            .drop   (drop_o[p]),
            .starve (starve_o[p])
        );
    end

    // Violation: grant to a non-requesting port, or more than one grant.
    always_comb begin
        proto_err = (|(gnt_i & ~req_o)) || !$onehot0(gnt_i);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_err_o <= 1'b0;
        end else if (proto_err) begin
            grant_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_client.sv
// Directed bench for arb_req_client driven by a fixed-priority arbiter model
// (port 0 highest), with an override for injecting illegal grants.
module tb_arb_req_client;

    logic       clk;
    logic       reset;
    logic [3:0] push_i;
    logic [3:0] gnt_i;
    logic [3:0] req_o;
    logic [3:0] full_o;
    logic [3:0] done_o;
    logic [3:0] drop_o;
    logic [3:0] starve_o;
    logic       grant_err_o;

    logic       force_en;
    logic [3:0] force_gnt;
    logic [3:0] arb_gnt;

    int total;
    int bad;

    arb_req_client #(
        .NUM_PORTS    (4),
        .CNT_W        (4),
        .STARVE_LIMIT (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_i),
        .gnt_i       (gnt_i),
        .req_o       (req_o),
        .full_o      (full_o),
        .done_o      (done_o),
        .drop_o      (drop_o),
        .starve_o    (starve_o),
        .grant_err_o (grant_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-priority arbiter: lowest-index requester wins.
    always_comb begin
        arb_gnt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req_o[i] && (arb_gnt == '0)) arb_gnt[i] = 1'b1;
        end
        gnt_i = force_en ? force_gnt : arb_gnt;
    end

    typedef struct packed {
        logic [3:0] push;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] drop;
        logic [3:0] full;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int done2_cnt;

    initial begin
        total     = 0;
        bad       = 0;
        force_en  = 1'b0;
        force_gnt = '0;
        push_i    = 4'hF;
        reset     = 1'b1;

        // Reset held two cycles with pushes active.
        tick();
        tick();
        chk("rst_req",    32'(req_o),       32'h0);
        chk("rst_done",   32'(done_o),      32'h0);
        chk("rst_err",    32'(grant_err_o), 32'h0);
        chk("rst_full",   32'(full_o),      32'h0);
        chk("rst_starve", 32'(starve_o),    32'h0);

        // push, req, done, drop, full after the edge
        vecs[0] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vecs[1] = '{4'h0, 4'hE, 4'h1, 4'h0, 4'h0};
        vecs[2] = '{4'h0, 4'hC, 4'h2, 4'h0, 4'h0};
        vecs[3] = '{4'h0, 4'h8, 4'h4, 4'h0, 4'h0};
        vecs[4] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
        vecs[5] = '{4'h9, 4'h9, 4'h0, 4'h0, 4'h0};
        vecs[6] = '{4'h0, 4'h8, 4'h1, 4'h0, 4'h0};
        vecs[7] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0};
        vecs[8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

        reset = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            push_i = vecs[i].push;
            tick();
            chk($sformatf("vec%0d_req",  i), 32'(req_o),  32'(vecs[i].req));
            chk($sformatf("vec%0d_done", i), 32'(done_o), 32'(vecs[i].done));
            chk($sformatf("vec%0d_drop", i), 32'(drop_o), 32'(vecs[i].drop));
            chk($sformatf("vec%0d_full", i), 32'(full_o), 32'(vecs[i].full));
        end

        // Fill port 2 while port 0 hogs the arbiter; 16th push is dropped.
        push_i = 4'b0101;
        for (int unsigned k = 1; k <= 16; k++) begin
            tick();
            if (k == 14) chk("fill14_full2", 32'(full_o[2]), 32'h0);
            if (k == 15) begin
                chk("fill15_full2", 32'(full_o[2]), 32'h1);
                chk("fill15_drop2", 32'(drop_o[2]), 32'h0);
            end
            if (k == 16) begin
                chk("fill16_full2", 32'(full_o[2]), 32'h1);
                chk("fill16_drop2", 32'(drop_o[2]), 32'h1);
                chk("fill16_done0", 32'(done_o[0]), 32'h1);
                chk("fill16_req",   32'(req_o),     32'h5);
            end
        end
        push_i    = 4'h0;
        done2_cnt = 0;
        for (int unsigned k = 0; k < 40; k++) begin
            tick();
            if (done_o[2]) done2_cnt++;
        end
        chk("drain_done2_count", 32'(done2_cnt), 32'd15);
        chk("drain_req",         32'(req_o),     32'h0);
        chk("drain_drop",        32'(drop_o),    32'h0);

        // Port 3 starves behind a continuously pushed port 0.
        push_i = 4'b1001;
        tick();
        push_i = 4'b0001;
        for (int unsigned k = 1; k <= 15; k++) begin
            tick();
            if (k == 14) chk("starve14", 32'(starve_o), 32'h0);
            if (k == 15) begin
                chk("starve15",      32'(starve_o), 32'h8);
                chk("starve15_req",  32'(req_o),    32'h9);
                chk("starve15_done", 32'(done_o),   32'h1);
            end
        end
        push_i = 4'h0;
        tick();
        chk("unstarve_a_starve", 32'(starve_o), 32'h8);
        chk("unstarve_a_req",    32'(req_o),    32'h8);
        tick();
        chk("unstarve_b_starve", 32'(starve_o), 32'h0);
        chk("unstarve_b_done",   32'(done_o),   32'h8);
        chk("unstarve_b_req",    32'(req_o),    32'h0);

        // Illegal grant vector while only port 1 requests.
        push_i = 4'b0010;
        tick();
        push_i    = 4'h0;
        force_en  = 1'b1;
        force_gnt = 4'b0110;
        chk("err_pre", 32'(grant_err_o), 32'h0);
        tick();
        chk("err_set",  32'(grant_err_o), 32'h1);
        chk("err_req",  32'(req_o),       32'h0);
        chk("err_done", 32'(done_o),      32'h2);
        force_en = 1'b0;
        tick();
        tick();
        tick();
        chk("err_sticky", 32'(grant_err_o), 32'h1);
        chk("err_idle_req", 32'(req_o),     32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_cleared", 32'(grant_err_o), 32'h0);

        // Reset with five transactions pending on port 1.
        force_en  = 1'b1;
        force_gnt = 4'h0;
        push_i    = 4'b0010;
        for (int unsigned k = 0; k < 5; k++) tick();
        chk("pend_req",  32'(req_o),  32'h2);
        chk("pend_full", 32'(full_o), 32'h0);
        push_i   = 4'h0;
        force_en = 1'b0;
        reset    = 1'b1;
        tick();
        chk("midrst_req",  32'(req_o),  32'h0);
        chk("midrst_done", 32'(done_o), 32'h0);
        reset = 1'b0;
        tick();
        chk("postrst_req",  32'(req_o),       32'h0);
        chk("postrst_done", 32'(done_o),      32'h0);
        chk("postrst_err",  32'(grant_err_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
